fsm_phase_sequencer: RTL and testbench



---
 rtl/fsm_pkg.sv | 31 +++
 rtl/fsm_phase_sequencer_phase_timer.sv | 49 ++++
 rtl/fsm_phase_sequencer.sv | 136 +++++++++++++
 tb/tb_fsm_phase_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// Shared state codes and phase enumeration for the row FSM and its phase sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fsm_pkg;

    localparam int MAST_FSM_BITS = 3;
    localparam int SLAV_FSM_BITS = 3;

    // Master FSM state codes
    localparam logic [MAST_FSM_BITS-1:0] M_IDLE  = 3'd0;
    localparam logic [MAST_FSM_BITS-1:0] M_LEFT  = 3'd1;
    localparam logic [MAST_FSM_BITS-1:0] M_BASE  = 3'd2;
    localparam logic [MAST_FSM_BITS-1:0] M_RIGHT = 3'd3;
    localparam logic [MAST_FSM_BITS-1:0] M_FSLD  = 3'd7;

    // Slave FSM state codes
    localparam logic [SLAV_FSM_BITS-1:0] S_IDLE = 3'd0;
    localparam logic [SLAV_FSM_BITS-1:0] S_TOP  = 3'd1;
    localparam logic [SLAV_FSM_BITS-1:0] S_MID  = 3'd2;
    localparam logic [SLAV_FSM_BITS-1:0] S_BOTT = 3'd3;

    // Phase currently being timed
    typedef enum logic [2:0] {
        PH_NONE = 3'd0,
        PH_FSLD = 3'd1,
        PH_TOP  = 3'd2,
        PH_MID  = 3'd3,
        PH_BOTT = 3'd4
    } phase_e;

endpackage

// File: rtl/fsm_phase_sequencer_phase_timer.sv
// Terminal-count phase timer that restarts whenever the timed phase changes.
// Latency: cnt/term are combinational from the count register and the phase input.
// Backpressure: none; advances every cycle while a phase is active.
//
// Ports: clk, reset (async active-low), phase (active phase), term_cnt (last
// cycle index of that phase), cnt (cycle index within phase), term (last cycle).
module phase_timer
    import fsm_pkg::*;
#(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  phase_e           phase,
    input  logic [CNT_W-1:0] term_cnt,
    output logic [CNT_W-1:0] cnt,
    output logic             term
);

    logic [CNT_W-1:0] cnt_q;
    phase_e           prev_q;

    // In normal sequencing the count is already 0 when a new phase begins,
    // because the previous phase ended on its terminal count. Masking on a
    // phase change only matters when the FSM skips a done: the new phase then
    // still starts at index 0 instead of inheriting a stale count.
    always_comb begin
        cnt = cnt_q;
        if (phase == PH_NONE || phase != prev_q) begin
            cnt = '0;
        end
        term = (phase != PH_NONE) && (cnt == term_cnt);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            prev_q <= PH_NONE;
        end else begin
            prev_q <= phase;
            if (phase == PH_NONE || term) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fsm_phase_sequencer.sv
// Generates the row FSM's phase-completion inputs by timing each master/slave phase.
// Latency: done/flag outputs are combinational decodes of registered counters (0 added cycles).
// Backpressure: none; the FSM state inputs are observed every cycle.
//
// Ports: clk, reset (async active-low), mast_state/slav_state (FSM state in),
// sl_top_done/sl_mid_done/sl_bott_done/flag_fsld_end (single-cycle phase ends),
// flag_base_end (level: last BASE pass), phase_cnt, col_idx, seq_err (sticky).
// Optional protocol checker: define PHASE_SEQ_ERRCHK_EN; otherwise seq_err is 0.
module fsm_phase_sequencer
    import fsm_pkg::*;
#(
    parameter int FSLD_CYCLES = 8,
    parameter int TOP_CYCLES  = 3,
    parameter int MID_CYCLES  = 4,
    parameter int BOTT_CYCLES = 3,
    parameter int BASE_COLS   = 2,
    parameter int CNT_W       = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [MAST_FSM_BITS-1:0] mast_state,
    input  logic [SLAV_FSM_BITS-1:0] slav_state,
    output logic                     sl_top_done,
    output logic                     sl_mid_done,
    output logic                     sl_bott_done,
    output logic                     flag_fsld_end,
    output logic                     flag_base_end,
    output logic [CNT_W-1:0]         phase_cnt,
    output logic [CNT_W-1:0]         col_idx,
    output logic                     seq_err
);

    localparam logic [CNT_W-1:0] TC_FSLD  = CNT_W'(FSLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TC_TOP   = CNT_W'(TOP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TC_MID   = CNT_W'(MID_CYCLES - 1);
    localparam logic [CNT_W-1:0] TC_BOTT  = CNT_W'(BOTT_CYCLES - 1);
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(BASE_COLS - 1);

    phase_e           act;
    logic [CNT_W-1:0] tc;
    logic             term;
    logic [CNT_W-1:0] col_q;

    // Active phase: FSLD is timed by the master alone; row phases are timed
    // only while the master is in a row state, so the slave's TOP tail after
    // RIGHT (master already idle) is ignored. Illegal codes fall to PH_NONE.
    always_comb begin
        act = PH_NONE;
        tc  = '0;
        if (mast_state == M_FSLD) begin
            act = PH_FSLD;
        end else if (mast_state == M_LEFT || mast_state == M_BASE || mast_state == M_RIGHT) begin
            case (slav_state)
                S_TOP:   act = PH_TOP;
                S_MID:   act = PH_MID;
                S_BOTT:  act = PH_BOTT;
                default: act = PH_NONE;
            endcase
        end
        case (act)
            PH_FSLD: tc = TC_FSLD;
            PH_TOP:  tc = TC_TOP;
            PH_MID:  tc = TC_MID;
            PH_BOTT: tc = TC_BOTT;
            default: tc = '0;
        endcase
    end

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .phase    (act),
        .term_cnt (tc),
        .cnt      (phase_cnt),
        .term     (term)
    );

    assign flag_fsld_end = term && (act == PH_FSLD);
    assign sl_top_done   = term && (act == PH_TOP);
    assign sl_mid_done   = term && (act == PH_MID);
    assign sl_bott_done  = term && (act == PH_BOTT);

    // Column index saturates on the last pass so flag_base_end stays high
    // until the master leaves BASE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q <= '0;
        end else if (mast_state != M_BASE) begin
            col_q <= '0;
        end else if (sl_bott_done && (col_q < COL_LAST)) begin
            col_q <= col_q + CNT_W'(1);
        end
    end

    assign col_idx       = col_q;
    assign flag_base_end = (mast_state == M_BASE) && (col_q == COL_LAST);

`ifdef PHASE_SEQ_ERRCHK_EN
    phase_e prev_ph_q;
    logic   prev_term_q;
    logic   err_q;
    logic   mast_bad;
    logic   slav_bad;
    logic   slav_skip;
    logic   fsld_skip;

    // A phase may only be left on the cycle after its terminal count.
    always_comb begin
        mast_bad  = !(mast_state inside {M_IDLE, M_LEFT, M_BASE, M_RIGHT, M_FSLD});
        slav_bad  = (mast_state != M_IDLE) &&
                    !(slav_state inside {S_IDLE, S_TOP, S_MID, S_BOTT});
        slav_skip = (prev_ph_q inside {PH_TOP, PH_MID, PH_BOTT}) &&
                    (act != prev_ph_q) && !prev_term_q;
        fsld_skip = (prev_ph_q == PH_FSLD) && (act != PH_FSLD) && !prev_term_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_ph_q   <= PH_NONE;
            prev_term_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            prev_ph_q   <= act;
            prev_term_q <= term;
            err_q       <= err_q | mast_bad | slav_bad | slav_skip | fsld_skip;
        end
    end

    assign seq_err = err_q;
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_phase_sequencer.sv
// Bench: two sequencers (default, and TOP_CYCLES=1/BASE_COLS=1) each closed in a
// loop with a behavioural master/slave row FSM; expected pulses are queued and
// popped by a monitor whenever a done/flag pulse appears.
module tb_fsm_phase_sequencer;
    import fsm_pkg::*;

`ifdef PHASE_SEQ_ERRCHK_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    localparam logic [3:0] K_F = 4'b1000;
    localparam logic [3:0] K_T = 4'b0100;
    localparam logic [3:0] K_M = 4'b0010;
    localparam logic [3:0] K_B = 4'b0001;

    typedef struct {
        int         rel;
        logic [3:0] kind;
        int         cnt;
        int         col;
        logic       be;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_a, rst_b, start;
    logic       ovr;
    logic [2:0] ovr_m, ovr_s;
    logic [2:0] m_a, s_a, m_b, s_b;
    logic [2:0] mast_s[2];
    logic [2:0] slav_s[2];
    logic       top_d[2], mid_d[2], bott_d[2], fe[2], be[2], err[2];
    logic [8:0] pc[2], col[2];

    ev_t q_a[$];
    ev_t q_b[$];
    int  checks = 0;
    int  errors = 0;

    int         rel[2];
    logic [2:0] prevm[2];
    int         n_nonidle[2], n_top[2], n_mid[2], n_bott[2], n_be[2], n_base[2];
    logic [3:0] mon_p;
    ev_t        mon_e;

    always #5 clk = ~clk;

    assign mast_s[0] = ovr ? ovr_m : m_a;
    assign slav_s[0] = ovr ? ovr_s : s_a;
    assign mast_s[1] = m_b;
    assign slav_s[1] = s_b;

    fsm_phase_sequencer u_dut_a (
        .clk(clk), .reset(rst_a), .mast_state(mast_s[0]), .slav_state(slav_s[0]),
        .sl_top_done(top_d[0]), .sl_mid_done(mid_d[0]), .sl_bott_done(bott_d[0]),
        .flag_fsld_end(fe[0]), .flag_base_end(be[0]), .phase_cnt(pc[0]),
        .col_idx(col[0]), .seq_err(err[0])
    );

    fsm_phase_sequencer #(.TOP_CYCLES(1), .BASE_COLS(1)) u_dut_b (
        .clk(clk), .reset(rst_b), .mast_state(mast_s[1]), .slav_state(slav_s[1]),
        .sl_top_done(top_d[1]), .sl_mid_done(mid_d[1]), .sl_bott_done(bott_d[1]),
        .flag_fsld_end(fe[1]), .flag_base_end(be[1]), .phase_cnt(pc[1]),
        .col_idx(col[1]), .seq_err(err[1])
    );

    // Behavioural master/slave row FSM driven by the sequencer's completions.
    function automatic logic [5:0] fsm_next(input logic [2:0] m, input logic [2:0] s,
                                            input logic st, input logic fe_i, input logic td,
                                            input logic md, input logic bd, input logic be_i);
        logic [2:0] mn, sn;
        mn = m;
        sn = s;
        case (m)
            M_IDLE:  if (st) mn = M_FSLD;
            M_FSLD:  if (fe_i) mn = M_LEFT;
            M_LEFT:  if (bd) mn = M_BASE;
            M_BASE:  if (bd && be_i) mn = M_RIGHT;
            M_RIGHT: if (bd) mn = M_IDLE;
            default: mn = M_IDLE;
        endcase
        case (s)
            S_IDLE:  if (m == M_LEFT || m == M_BASE || m == M_RIGHT) sn = S_TOP;
            S_TOP:   if (m == M_IDLE) sn = S_IDLE; else if (td) sn = S_MID;
            S_MID:   if (md) sn = S_BOTT;
            S_BOTT:  if (bd) sn = S_TOP;
            default: sn = S_IDLE;
        endcase
        return {mn, sn};
    endfunction

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) {m_a, s_a} <= {M_IDLE, S_IDLE};
        else {m_a, s_a} <= fsm_next(mast_s[0], slav_s[0], start, fe[0], top_d[0],
                                     mid_d[0], bott_d[0], be[0]);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) {m_b, s_b} <= {M_IDLE, S_IDLE};
        else {m_b, s_b} <= fsm_next(mast_s[1], slav_s[1], start, fe[1], top_d[1],
                                     mid_d[1], bott_d[1], be[1]);
    end

    task automatic add_ev(input int id, input int r, input logic [3:0] k, input int c,
                          input int cl, input logic b);
        ev_t e;
        e.rel = r; e.kind = k; e.cnt = c; e.col = cl; e.be = b;
        if (id == 0) q_a.push_back(e);
        else q_b.push_back(e);
    endtask

    // rel = cycles since master entered FSLD. Hand-derived timeline, default
    // instance: FSLD 0-7, LEFT 8-18 (slave idle at 8), BASE 19-38, RIGHT 39-48.
    task automatic push_frame_a(input int upto);
        ev_t t[$];
        t = '{'{7, K_F, 7, 0, 1'b0}, '{11, K_T, 2, 0, 1'b0}, '{15, K_M, 3, 0, 1'b0},
              '{18, K_B, 2, 0, 1'b0}, '{21, K_T, 2, 0, 1'b0}, '{25, K_M, 3, 0, 1'b0},
              '{28, K_B, 2, 0, 1'b0}, '{31, K_T, 2, 1, 1'b1}, '{35, K_M, 3, 1, 1'b1},
              '{38, K_B, 2, 1, 1'b1}, '{41, K_T, 2, 0, 1'b0}, '{45, K_M, 3, 0, 1'b0},
              '{48, K_B, 2, 0, 1'b0}};
        foreach (t[i]) if (t[i].rel <= upto) add_ev(0, t[i].rel, t[i].kind, t[i].cnt, t[i].col, t[i].be);
    endtask

    // TOP=1, one BASE pass: FSLD 0-7, LEFT 8-16, BASE 17-24, RIGHT 25-32.
    task automatic push_frame_b();
        add_ev(1, 7, K_F, 7, 0, 1'b0);  add_ev(1, 9, K_T, 0, 0, 1'b0);
        add_ev(1, 13, K_M, 3, 0, 1'b0); add_ev(1, 16, K_B, 2, 0, 1'b0);
        add_ev(1, 17, K_T, 0, 0, 1'b1); add_ev(1, 21, K_M, 3, 0, 1'b1);
        add_ev(1, 24, K_B, 2, 0, 1'b1); add_ev(1, 25, K_T, 0, 0, 1'b0);
        add_ev(1, 29, K_M, 3, 0, 1'b0); add_ev(1, 32, K_B, 2, 0, 1'b0);
    endtask

    // Monitor: any done/flag pulse pops the next expected event for that DUT.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mast_s[i] == M_FSLD && prevm[i] != M_FSLD) rel[i] = 0;
            else rel[i] = rel[i] + 1;
            prevm[i] = mast_s[i];
            if (mast_s[i] != M_IDLE) n_nonidle[i] = n_nonidle[i] + 1;
            if (mast_s[i] == M_BASE) n_base[i] = n_base[i] + 1;
            if (be[i]) n_be[i] = n_be[i] + 1;
            if (top_d[i]) n_top[i] = n_top[i] + 1;
            if (mid_d[i]) n_mid[i] = n_mid[i] + 1;
            if (bott_d[i]) n_bott[i] = n_bott[i] + 1;
            mon_p = {fe[i], top_d[i], mid_d[i], bott_d[i]};
            if (mon_p != 4'b0000) begin
                checks++;
                if ((i == 0 && q_a.size() == 0) || (i == 1 && q_b.size() == 0)) begin
                    errors++;
                    $display("FAIL unexpected_pulse dut%0d: got kind=%b at rel %0d, required no pulse",
                             i, mon_p, rel[i]);
                end else begin
                    if (i == 0) mon_e = q_a.pop_front();
                    else mon_e = q_b.pop_front();
                    if (mon_e.rel != rel[i] || mon_e.kind != mon_p || mon_e.cnt != int'(pc[i]) ||
                        mon_e.col != int'(col[i]) || mon_e.be != be[i]) begin
                        errors++;
                        $display("FAIL pulse dut%0d: got rel=%0d kind=%b cnt=%0d col=%0d be=%b, required rel=%0d kind=%b cnt=%0d col=%0d be=%b",
                                 i, rel[i], mon_p, pc[i], col[i], be[i],
                                 mon_e.rel, mon_e.kind, mon_e.cnt, mon_e.col, mon_e.be);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int id, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d, required %0d", name, id, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string name, input int id);
        chk({name, "_top"}, id, int'(top_d[id]), 0);
        chk({name, "_mid"}, id, int'(mid_d[id]), 0);
        chk({name, "_bott"}, id, int'(bott_d[id]), 0);
        chk({name, "_fsld_end"}, id, int'(fe[id]), 0);
        chk({name, "_base_end"}, id, int'(be[id]), 0);
        chk({name, "_phase_cnt"}, id, int'(pc[id]), 0);
        chk({name, "_col_idx"}, id, int'(col[id]), 0);
        chk({name, "_seq_err"}, id, int'(err[id]), 0);
    endtask

    int s_nonidle[2], s_top, s_mid, s_bott, s_be, s_base_b;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; start = 1'b0;
        ovr = 1'b0; ovr_m = M_IDLE; ovr_s = S_IDLE;
        #2;
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset", 0);
        chk_all_zero("reset", 1);
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) @(negedge clk);

        // Full frame on both instances.
        push_frame_a(99);
        push_frame_b();
        for (int i = 0; i < 2; i++) s_nonidle[i] = n_nonidle[i];
        s_top = n_top[0]; s_mid = n_mid[0]; s_bott = n_bott[0]; s_be = n_be[0];
        s_base_b = n_base[1];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (60) @(negedge clk);
        chk("frame_nonidle", 0, n_nonidle[0] - s_nonidle[0], 49);
        chk("frame_top_pulses", 0, n_top[0] - s_top, 4);
        chk("frame_mid_pulses", 0, n_mid[0] - s_mid, 4);
        chk("frame_bott_pulses", 0, n_bott[0] - s_bott, 4);
        chk("base_end_cycles", 0, n_be[0] - s_be, 10);
        chk("frame_nonidle", 1, n_nonidle[1] - s_nonidle[1], 33);
        chk("base_cycles", 1, n_base[1] - s_base_b, 8);
        chk("events_left", 0, q_a.size(), 0);
        chk("events_left", 1, q_b.size(), 0);
        chk("seq_err_clean", 0, int'(err[0]), 0);
        chk("seq_err_clean", 1, int'(err[1]), 0);
        chk("end_idle", 0, int'(mast_s[0]), int'(M_IDLE));

        // Reset in BASE/MID with phase_cnt=2 (rel 24) on instance A.
        push_frame_a(21);
        push_frame_b();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (24) @(negedge clk);
        chk("pre_reset_mast", 0, int'(mast_s[0]), int'(M_BASE));
        chk("pre_reset_slav", 0, int'(slav_s[0]), int'(S_MID));
        chk("pre_reset_phase_cnt", 0, int'(pc[0]), 2);
        #1 rst_a = 1'b0;
        #1 chk_all_zero("mid_reset", 0);
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_reset_events_left", 0, q_a.size(), 0);
        chk("post_reset_mast", 0, int'(mast_s[0]), int'(M_IDLE));
        chk("second_frame_events_left", 1, q_b.size(), 0);

        // Slave TOP -> BOTT with no done in between.
        ovr = 1'b1; ovr_m = M_LEFT; ovr_s = S_TOP;
        @(negedge clk);
        chk("seq_err_before_skip", 0, int'(err[0]), 0);
        ovr_s = S_BOTT;
        @(negedge clk);
        chk("seq_err_after_skip", 0, int'(err[0]), EXP_ERR);
        ovr_m = M_IDLE; ovr_s = S_IDLE;
        repeat (3) @(negedge clk);
        chk("seq_err_sticky", 0, int'(err[0]), EXP_ERR);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
